// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: buffers CPU VRAM writes in a FIFO and replays them into
// the GPU VRAM write port only while the video timing reports a writable window.

package mapache64;
   typedef logic [11:0] vram_address_t;
   typedef logic [7:0]  data_t;
endpackage

module vram_write_scheduler
   import mapache64::*;
#(
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          gpu_clk,
   input  logic          rst_n,
   input  logic          wen_i,
   input  vram_address_t address_i,
   input  data_t         data_i,
   input  logic [4:0]    select_i,
   input  vram_address_t rd_address_i,
   input  logic [4:0]    rd_select_i,
   input  logic          writable_i,
   input  logic          bypass_i,
   input  logic          clr_overflow_i,
   output logic          wen_o,
   output vram_address_t address_o,
   output data_t         data_o,
   output logic [4:0]    select_o,
   output logic          ready_o,
   output logic [CW-1:0] count_o,
   output logic          overflow_o,
   output logic          hazard_o
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [4:0]    select;
      vram_address_t address;
      data_t         data;
   } entry_t;

   typedef enum logic {
      S_IDLE,
      S_DRAIN
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   entry_t          r_mem [DEPTH];
   entry_t          r_out;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;

   logic            w_push;
   logic            w_full;
   logic            w_drain;
   logic            w_push_ok;
   logic            w_drop;
   logic            w_hazard;
   logic [PW-1:0]   w_offset [DEPTH];
   logic [DEPTH-1:0] w_valid;

   assign w_push    = wen_i & (|select_i);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_drain   = (writable_i | bypass_i) & (r_count != '0);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push_ok = w_push & (~w_full | w_drain);
   assign w_drop    = w_push & w_full & ~w_drain;

   // NOTE: storage has no reset; entries are only read once the pointers mark them valid.
   always_ff @(posedge gpu_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= '{select: select_i, address: address_i, data: data_i};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_drain) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         unique case ({w_push_ok, w_drain})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
      end else if (w_drain) begin
         r_out <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow_i) begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_drain)  w_state_next = S_DRAIN;
         S_DRAIN: if (!w_drain) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Slot i is pending when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_offset[i] = PW'(i) - r_rd_ptr;
         w_valid[i]  = (CW'(w_offset[i]) < r_count);
      end
   end

   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_valid[i] && (r_mem[i].select == rd_select_i)
                        && (r_mem[i].address == rd_address_i)) begin
            w_hazard = 1'b1;
         end
      end
      w_hazard = w_hazard & (|rd_select_i);
   end

   assign wen_o      = (r_state == S_DRAIN);
   assign address_o  = r_out.address;
   assign data_o     = r_out.data;
   assign select_o   = r_out.select;
   assign ready_o    = ~w_full;
   assign count_o    = r_count;
   assign overflow_o = r_overflow;
   assign hazard_o   = w_hazard;

endmodule
